// File: rtl/cell_free_list.sv
// Circular free list of packet-buffer cell IDs: seeds every cell after reset, expands multi-cell frees into
// one push per cycle, and offers allocation as a valid/ready stream. Optional macro: CELL_FREE_LIST_DOUBLE_FREE_CHECK_EN.
module cell_free_list #(
    parameter int RAM_ADDR_WIDTH = 16,
    parameter int LEN_WIDTH      = 16,
    parameter int CELL_ID_WIDTH  = 8,
    parameter int CELL_SIZE      = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      free_mem_req,
    input  logic [LEN_WIDTH-1:0]      free_mem_size,
    input  logic [RAM_ADDR_WIDTH-1:0] free_mem_addr,
    output logic                      free_mem_ready,
    output logic [CELL_ID_WIDTH-1:0]  m_alloc_cell_id,
    output logic                      m_alloc_valid,
    input  logic                      m_alloc_ready,
    output logic [CELL_ID_WIDTH:0]    free_count,
    output logic                      init_done,
    output logic                      err_double_free
);

    localparam int CELL_COUNT  = 2 ** CELL_ID_WIDTH;
    localparam int OFFSET_BITS = $clog2(CELL_SIZE);
    localparam int CW          = CELL_ID_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_FREE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [CELL_ID_WIDTH-1:0] head_q, head_d;
    logic [CELL_ID_WIDTH-1:0] tail_q, tail_d;
    logic [CELL_ID_WIDTH-1:0] next_id_q, next_id_d;
    logic [LEN_WIDTH-1:0]     remain_q, remain_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     init_done_q, init_done_d;
    logic [CELL_ID_WIDTH-1:0] mem_q [CELL_COUNT];

    logic                     init_push;
    logic                     free_push;
    logic                     accept;
    logic                     push_req;
    logic                     push_ok;
    logic                     pop;
    logic                     full;
    logic                     seed_last;
    logic [CELL_ID_WIDTH-1:0] push_id;
    logic [CELL_ID_WIDTH-1:0] req_id;
    logic                     unused_addr_bits;

    // Only the cell-index field of the byte address matters.
    assign req_id           = free_mem_addr[OFFSET_BITS +: CELL_ID_WIDTH];
    assign unused_addr_bits = ^free_mem_addr;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: begin
                if (seed_last) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (free_mem_req && (free_mem_size > LEN_WIDTH'(1))) state_d = ST_FREE;
            end
            ST_FREE: begin
                if (remain_q == LEN_WIDTH'(1)) state_d = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        free_mem_ready = 1'b0;
        init_push      = 1'b0;
        free_push      = 1'b0;
        case (state_q)
            ST_INIT: init_push      = 1'b1;
            ST_IDLE: free_mem_ready = 1'b1;
            ST_FREE: free_push      = 1'b1;
            default: init_push      = 1'b0;
        endcase
    end

    assign seed_last = init_push && (tail_q == {CELL_ID_WIDTH{1'b1}});
    assign accept    = free_mem_req && free_mem_ready;
    assign full      = (count_q == CW'(CELL_COUNT));
    assign pop       = m_alloc_valid && m_alloc_ready;

    // During seeding the tail pointer doubles as the ID being written.
    always_comb begin
        push_req = 1'b0;
        push_id  = '0;
        if (init_push) begin
            push_req = 1'b1;
            push_id  = tail_q;
        end else if (free_push) begin
            push_req = 1'b1;
            push_id  = next_id_q;
        end else if (accept && (free_mem_size != '0)) begin
            push_req = 1'b1;
            push_id  = req_id;
        end
    end

`ifdef CELL_FREE_LIST_DOUBLE_FREE_CHECK_EN
    logic [CELL_COUNT-1:0] alloc_map_q, alloc_map_d;
    logic                  err_q, err_d;
    logic                  dbl_free;

    // The push is judged against the bitmap before this cycle's alloc update.
    assign dbl_free = push_req && !init_push && !alloc_map_q[push_id];
    assign push_ok  = push_req && !full && !dbl_free;

    always_comb begin
        alloc_map_d = alloc_map_q;
        if (push_ok) alloc_map_d[push_id] = 1'b0;
        if (pop)     alloc_map_d[head_q]  = 1'b1;
        err_d = err_q | dbl_free;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_map_q <= '0;
            err_q       <= 1'b0;
        end else begin
            alloc_map_q <= alloc_map_d;
            err_q       <= err_d;
        end
    end

    assign err_double_free = err_q;
`else
    assign push_ok         = push_req && !full;
    assign err_double_free = 1'b0;
`endif

    // ---------------- pointer / count / expansion datapath ----------------
    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        next_id_d   = next_id_q;
        remain_d    = remain_q;
        init_done_d = init_done_q | seed_last;

        if (push_ok) tail_d = tail_q + CELL_ID_WIDTH'(1);
        if (pop)     head_d = head_q + CELL_ID_WIDTH'(1);
        count_d = count_q + CW'(push_ok) - CW'(pop);

        if (free_push) begin
            next_id_d = next_id_q + CELL_ID_WIDTH'(1);
            remain_d  = remain_q - LEN_WIDTH'(1);
        end else if (accept && (free_mem_size > LEN_WIDTH'(1))) begin
            next_id_d = req_id + CELL_ID_WIDTH'(1);
            remain_d  = free_mem_size - LEN_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            next_id_q   <= '0;
            remain_q    <= '0;
            init_done_q <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            next_id_q   <= next_id_d;
            remain_q    <= remain_d;
            init_done_q <= init_done_d;
        end
    end

    // Storage carries no reset; seeding rewrites every entry before it can be read.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[tail_q] <= push_id;
    end

    assign m_alloc_valid   = init_done_q && (count_q != '0);
    assign m_alloc_cell_id = init_done_q ? mem_q[head_q] : '0;
    assign free_count      = count_q;
    assign init_done       = init_done_q;

endmodule

// File: tb/tb_cell_free_list.sv
// Directed bench for cell_free_list: vector tables for alloc/free traffic plus hand-written
// sequences for seeding, a long drain to the wrap point, and reset during a multi-cell free.
module tb_cell_free_list;

`ifdef CELL_FREE_LIST_DOUBLE_FREE_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        free_mem_req;
    logic [15:0] free_mem_size;
    logic [15:0] free_mem_addr;
    logic        free_mem_ready;
    logic [7:0]  m_alloc_cell_id;
    logic        m_alloc_valid;
    logic        m_alloc_ready;
    logic [8:0]  free_count;
    logic        init_done;
    logic        err_double_free;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        req;
        logic [15:0] size;
        logic [15:0] addr;
        logic        rdy;
        logic        exp_ready;
        logic        exp_valid;
        logic [7:0]  exp_id;
        logic [8:0]  exp_count;
        logic        exp_err;
    } vec_t;

    vec_t vq[$];

    cell_free_list dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .free_mem_req   (free_mem_req),
        .free_mem_size  (free_mem_size),
        .free_mem_addr  (free_mem_addr),
        .free_mem_ready (free_mem_ready),
        .m_alloc_cell_id(m_alloc_cell_id),
        .m_alloc_valid  (m_alloc_valid),
        .m_alloc_ready  (m_alloc_ready),
        .free_count     (free_count),
        .init_done      (init_done),
        .err_double_free(err_double_free)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ready"}, 32'(free_mem_ready), 0);
        chk({tag, "_valid"}, 32'(m_alloc_valid), 0);
        chk({tag, "_id"}, 32'(m_alloc_cell_id), 0);
        chk({tag, "_count"}, 32'(free_count), 0);
        chk({tag, "_init_done"}, 32'(init_done), 0);
        chk({tag, "_err"}, 32'(err_double_free), 0);
    endtask

    // Counts rising edges from reset release until init_done is seen, bounded.
    task automatic wait_init(output int cyc);
        cyc = 0;
        while (!init_done && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic seed_checks(input string tag);
        int cyc;
        wait_init(cyc);
        chk({tag, "_init_cycles"}, 32'(cyc), 256);
        chk({tag, "_count"}, 32'(free_count), 256);
        chk({tag, "_id"}, 32'(m_alloc_cell_id), 0);
        chk({tag, "_valid"}, 32'(m_alloc_valid), 1);
        chk({tag, "_ready"}, 32'(free_mem_ready), 1);
    endtask

    task automatic add_vec(input logic req, input logic [15:0] size, input logic [15:0] addr,
                           input logic rdy, input logic e_ready, input logic e_valid,
                           input logic [7:0] e_id, input logic [8:0] e_count, input logic e_err);
        vec_t v;
        v.req = req; v.size = size; v.addr = addr; v.rdy = rdy;
        v.exp_ready = e_ready; v.exp_valid = e_valid; v.exp_id = e_id;
        v.exp_count = e_count; v.exp_err = e_err;
        vq.push_back(v);
    endtask

    // Inputs are driven just after a rising edge; outputs are compared mid-cycle, then one edge is taken.
    task automatic run_vectors(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            free_mem_req  = vq[i].req;
            free_mem_size = vq[i].size;
            free_mem_addr = vq[i].addr;
            m_alloc_ready = vq[i].rdy;
            #1;
            chk($sformatf("vec%0d_ready", i), 32'(free_mem_ready), 32'(vq[i].exp_ready));
            chk($sformatf("vec%0d_valid", i), 32'(m_alloc_valid), 32'(vq[i].exp_valid));
            chk($sformatf("vec%0d_id", i), 32'(m_alloc_cell_id), 32'(vq[i].exp_id));
            chk($sformatf("vec%0d_count", i), 32'(free_count), 32'(vq[i].exp_count));
            chk($sformatf("vec%0d_err", i), 32'(err_double_free), 32'(vq[i].exp_err));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Table A (0..9): three allocs, a stalled cycle, two more, then free 0x0100 x3.
        //       req  size   addr     rdy  ready valid id   count err
        add_vec(0, 16'd0, 16'h0000, 1,   1,    1,    0,   256,  0);
        add_vec(0, 16'd0, 16'h0000, 1,   1,    1,    1,   255,  0);
        add_vec(0, 16'd0, 16'h0000, 1,   1,    1,    2,   254,  0);
        add_vec(0, 16'd0, 16'h0000, 0,   1,    1,    3,   253,  0);
        add_vec(0, 16'd0, 16'h0000, 1,   1,    1,    3,   253,  0);
        add_vec(0, 16'd0, 16'h0000, 1,   1,    1,    4,   252,  0);
        add_vec(1, 16'd3, 16'h0100, 0,   1,    1,    5,   251,  0);
        add_vec(0, 16'd0, 16'h0000, 0,   0,    1,    5,   252,  0);
        add_vec(0, 16'd0, 16'h0000, 0,   0,    1,    5,   253,  0);
        add_vec(0, 16'd0, 16'h0000, 0,   1,    1,    5,   254,  0);
        // Table B (10..20): wrapping free of 255,0 with concurrent pops, drain, no-op, double free.
        add_vec(1, 16'd2, 16'hFF00, 1,   1,    1,    1,   3,    0);
        add_vec(0, 16'd0, 16'h0000, 1,   0,    1,    2,   3,    0);
        add_vec(0, 16'd0, 16'h0000, 1,   1,    1,    3,   3,    0);
        add_vec(0, 16'd0, 16'h0000, 1,   1,    1,    255, 2,    0);
        add_vec(0, 16'd0, 16'h0000, 1,   1,    1,    0,   1,    0);
        add_vec(0, 16'd0, 16'h0000, 1,   1,    0,    5,   0,    0);
        add_vec(1, 16'd0, 16'h1234, 0,   1,    0,    5,   0,    0);
        add_vec(1, 16'd1, 16'h0A7F, 0,   1,    0,    5,   0,    0);
        add_vec(0, 16'd0, 16'h0000, 0,   1,    1,    10,  1,    0);
        add_vec(1, 16'd1, 16'h0A00, 0,   1,    1,    10,  1,    0);
        add_vec(0, 16'd0, 16'h0000, 0,   1,    1,    10,  CHK ? 9'd1 : 9'd2, CHK);

        rst_n         = 1'b0;
        free_mem_req  = 1'b0;
        free_mem_size = '0;
        free_mem_addr = '0;
        m_alloc_ready = 1'b0;

        // Reset values while held in reset.
        repeat (3) @(posedge clk);
        #1;
        chk_reset_values("reset");

        rst_n = 1'b1;
        seed_checks("seed");

        run_vectors(0, 9);

        // Drain cells 5..255 so that 255 and 0 are both allocated and head wraps to 0.
        m_alloc_ready = 1'b1;
        for (int i = 0; i < 251; i++) begin
            #1;
            chk($sformatf("drain%0d_id", i), 32'(m_alloc_cell_id), 32'(5 + i));
            chk($sformatf("drain%0d_count", i), 32'(free_count), 32'(254 - i));
            @(posedge clk);
            #1;
        end
        m_alloc_ready = 1'b0;

        run_vectors(10, 20);

        // Size-8 free interrupted by reset.
        free_mem_req  = 1'b1;
        free_mem_size = 16'd8;
        free_mem_addr = 16'h2000;
        #1;
        chk("free8_accept_ready", 32'(free_mem_ready), 1);
        @(posedge clk);
        #1;
        free_mem_req = 1'b0;
        chk("free8_busy1", 32'(free_mem_ready), 0);
        @(posedge clk);
        #1;
        chk("free8_busy2", 32'(free_mem_ready), 0);
        rst_n = 1'b0;
        #1;
        chk_reset_values("midfree_reset");
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        seed_checks("reseed");

        // Push into a full list is discarded.
        free_mem_req  = 1'b1;
        free_mem_size = 16'd1;
        free_mem_addr = 16'h0500;
        @(posedge clk);
        #1;
        free_mem_req = 1'b0;
        #1;
        chk("full_push_count", 32'(free_count), 256);
        chk("full_push_id", 32'(m_alloc_cell_id), 0);
        chk("full_push_ready", 32'(free_mem_ready), 1);
        chk("full_push_err", 32'(err_double_free), 32'(CHK));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
